// File: rtl/llc_lookup_sched.sv
// LLC way-lookup scheduler: round-robin arbitration, fixed-latency set-buffer read,
// way-lookup pulse and a valid/ready response, guarded by a small set-lock table.
module llc_lookup_sched #(
    parameter int NUM_REQ   = 3,
    parameter int SET_BITS  = 9,
    parameter int TAG_BITS  = 16,
    parameter int WAY_BITS  = 4,
    parameter int RD_LAT    = 1,
    parameter int NUM_LOCKS = 2,
    localparam int ID_BITS  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*SET_BITS-1:0]  req_set,
    input  logic [NUM_REQ*TAG_BITS-1:0]  req_tag,
    output logic                         rd_en,
    output logic [SET_BITS-1:0]          rd_set,
    output logic                         lookup_en,
    output logic [TAG_BITS-1:0]          lookup_tag,
    input  logic [WAY_BITS-1:0]          lk_way,
    input  logic                         lk_evict,
    output logic                         resp_valid,
    input  logic                         resp_ready,
    output logic [ID_BITS-1:0]           resp_id,
    output logic [SET_BITS-1:0]          resp_set,
    output logic [TAG_BITS-1:0]          resp_tag,
    output logic [WAY_BITS-1:0]          resp_way,
    output logic                         resp_evict,
    input  logic                         unlock_valid,
    input  logic [SET_BITS-1:0]          unlock_set,
    output logic                         lock_full
);
    localparam int CNT_BITS = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [2:0] {S_IDLE, S_RD, S_WAIT, S_LK, S_CAP, S_RESP} state_t;

    state_t               state_q, state_d;
    logic [ID_BITS-1:0]   rr_ptr, id_q, grant_idx;
    logic [SET_BITS-1:0]  set_q;
    logic [TAG_BITS-1:0]  tag_q;
    logic [WAY_BITS-1:0]  way_q;
    logic                 evict_q;
    logic [CNT_BITS-1:0]  wait_cnt;
    logic [NUM_REQ-1:0]   eligible;
    logic                 grant_found, grant_take, resp_hs;
    logic [NUM_LOCKS-1:0] lock_valid, lock_valid_d, alloc_oh;
    logic [SET_BITS-1:0]  lock_set [NUM_LOCKS];

    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = req_valid[i] && !lock_full;
            for (int j = 0; j < NUM_LOCKS; j++)
                if (lock_valid[j] && lock_set[j] == req_set[i*SET_BITS +: SET_BITS])
                    eligible[i] = 1'b0;
        end
    end

    // Search starts at the round-robin pointer and wraps.
    always_comb begin
        int idx;
        idx         = 0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!grant_found && eligible[idx]) begin
                grant_found = 1'b1;
                grant_idx   = ID_BITS'(idx);
            end
        end
    end

    assign grant_take = (state_q == S_IDLE) && grant_found;
    assign resp_hs    = (state_q == S_RESP) && resp_ready;

    // NOTE: req_ready is combinational, so it is also gated by rst to read 0 while reset is held.
    always_comb begin
        req_ready = '0;
        if (grant_take && rst)
            req_ready[grant_idx] = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (grant_found) state_d = S_RD;
            S_RD:   state_d = (RD_LAT == 1) ? S_LK : S_WAIT;
            S_WAIT: if (wait_cnt == '0) state_d = S_LK;
            S_LK:   state_d = S_CAP;
            S_CAP:  state_d = S_RESP;
            S_RESP: if (resp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: all sequential state uses non-blocking assignments; comb blocks use blocking.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr   <= '0;
            id_q     <= '0;
            set_q    <= '0;
            tag_q    <= '0;
            way_q    <= '0;
            evict_q  <= 1'b0;
            wait_cnt <= '0;
        end else begin
            if (grant_take) begin
                id_q   <= grant_idx;
                set_q  <= req_set[int'(grant_idx)*SET_BITS +: SET_BITS];
                tag_q  <= req_tag[int'(grant_idx)*TAG_BITS +: TAG_BITS];
                rr_ptr <= ID_BITS'((int'(grant_idx) + 1) % NUM_REQ);
            end
            if (state_q == S_RD)
                wait_cnt <= CNT_BITS'((RD_LAT > 1) ? RD_LAT - 2 : 0);
            else if (state_q == S_WAIT && wait_cnt != '0)
                wait_cnt <= wait_cnt - CNT_BITS'(1);
            if (state_q == S_CAP) begin
                way_q   <= lk_way;
                evict_q <= lk_evict;
            end
        end
    end

    // Allocation looks at the current valid bits, so an entry freed this cycle is not reused yet.
    always_comb begin
        logic found;
        found        = 1'b0;
        alloc_oh     = '0;
        lock_valid_d = lock_valid;
        for (int j = 0; j < NUM_LOCKS; j++)
            if (unlock_valid && lock_valid[j] && lock_set[j] == unlock_set)
                lock_valid_d[j] = 1'b0;
        for (int j = 0; j < NUM_LOCKS; j++)
            if (resp_hs && !found && !lock_valid[j]) begin
                found       = 1'b1;
                alloc_oh[j] = 1'b1;
            end
        lock_valid_d = lock_valid_d | alloc_oh;
    end

    // NOTE: the lock table is tiny and its contents feed eligibility, so every entry is reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lock_valid <= '0;
            lock_full  <= 1'b0;
            for (int j = 0; j < NUM_LOCKS; j++)
                lock_set[j] <= '0;
        end else begin
            lock_valid <= lock_valid_d;
            lock_full  <= &lock_valid_d;
            for (int j = 0; j < NUM_LOCKS; j++)
                if (alloc_oh[j])
                    lock_set[j] <= set_q;
        end
    end

    assign rd_en      = (state_q == S_RD);
    assign lookup_en  = (state_q == S_LK);
    assign resp_valid = (state_q == S_RESP);
    assign rd_set     = set_q;
    assign lookup_tag = tag_q;
    assign resp_id    = id_q;
    assign resp_set   = set_q;
    assign resp_tag   = tag_q;
    assign resp_way   = way_q;
    assign resp_evict = evict_q;

endmodule
